dual_fetch_unit: RTL and testbench

//  Fetch-side initiator for the dual-word instruction memory of the superscalar core.

---
 rtl/dual_fetch_unit_pkg.sv | 21 ++
 rtl/dual_fetch_unit_if.sv | 27 ++
 rtl/dual_fetch_unit_ifid_pair_reg.sv | 66 ++++++
 rtl/dual_fetch_unit.sv | 78 +++++++
 tb/tb_dual_fetch_unit.sv | 135 +++++++++++++
 5 files changed

// File: rtl/dual_fetch_unit_pkg.sv
// rtl/dual_fetch_unit_pkg.sv - shared constants, fetch action type and decode helper
package dual_fetch_unit_pkg;

  localparam logic [31:0] PC_STEP          = 32'd8;
  localparam logic [31:0] FETCH_ALIGN_MASK = ~32'h7;
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_REDIRECT = 2'd2
  } fetch_act_e;

  // A redirect overrides a concurrent stall so a taken branch is never lost.
  function automatic fetch_act_e decode_act(input logic redirect, input logic stall);
    if (redirect) return ACT_REDIRECT;
    if (stall) return ACT_STALL;
    return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/dual_fetch_unit_if.sv
// rtl/dual_fetch_unit_if.sv - control, instruction memory and IF/ID bus of the fetch unit
interface dual_fetch_unit_if #(
  parameter int COUNT_W = 16
);
  logic               stall;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [31:0]        imem_addr;
  logic [31:0]        imem_instr1;
  logic [31:0]        imem_instr2;
  logic [31:0]        id_instr0;
  logic [31:0]        id_instr1;
  logic               id_valid0;
  logic               id_valid1;
  logic [31:0]        id_pc;
  logic [COUNT_W-1:0] fetch_count;

  modport master (
    input  stall, redirect, redirect_pc, imem_instr1, imem_instr2,
    output imem_addr, id_instr0, id_instr1, id_valid0, id_valid1, id_pc, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_instr1, imem_instr2,
    input  imem_addr, id_instr0, id_instr1, id_valid0, id_valid1, id_pc, fetch_count
  );
endinterface

// File: rtl/dual_fetch_unit_ifid_pair_reg.sv
// rtl/dual_fetch_unit_ifid_pair_reg.sv - IF/ID instruction pair register with hold, flush and slot-0 suppression
module dual_fetch_unit_ifid_pair_reg #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        flush,
  input  logic        slot0_en,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_lo,
  input  logic [31:0] instr_hi,
  output logic [31:0] id_instr0,
  output logic [31:0] id_instr1,
  output logic        id_valid0,
  output logic        id_valid1,
  output logic [31:0] id_pc
);

  logic [31:0] instr0_q, instr0_d, instr1_q, instr1_d, pc_q, pc_d;
  logic        valid0_q, valid0_d, valid1_q, valid1_d;

  // Flush leaves id_pc alone; it is meaningless while both slots are invalid.
  always_comb begin
    instr0_d = instr0_q;
    instr1_d = instr1_q;
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    pc_d     = pc_q;
    if (flush) begin
      instr0_d = NOP_WORD;
      instr1_d = NOP_WORD;
      valid0_d = 1'b0;
      valid1_d = 1'b0;
    end else if (!hold) begin
      instr0_d = slot0_en ? instr_lo : NOP_WORD;
      valid0_d = slot0_en;
      instr1_d = instr_hi;
      valid1_d = 1'b1;
      pc_d     = pc_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr0_q <= NOP_WORD;
      instr1_q <= NOP_WORD;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      pc_q     <= 32'h0;
    end else begin
      instr0_q <= instr0_d;
      instr1_q <= instr1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      pc_q     <= pc_d;
    end
  end

  assign id_instr0 = instr0_q;
  assign id_instr1 = instr1_q;
  assign id_valid0 = valid0_q;
  assign id_valid1 = valid1_q;
  assign id_pc     = pc_q;

endmodule

// File: rtl/dual_fetch_unit.sv
// rtl/dual_fetch_unit.sv - dual-word fetch initiator: PC, odd-slot skip and issued-pair counter
module dual_fetch_unit
  import dual_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 16,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic             clk,
  input  logic             reset,
  dual_fetch_unit_if.master bus
);

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & FETCH_ALIGN_MASK;
  localparam logic [28:0] PC_INCR          = 29'(PC_STEP >> 3);

  logic [28:0]        pc_q, pc_d;
  logic               skip_lo_q, skip_lo_d;
  logic [COUNT_W-1:0] fetch_count_q, fetch_count_d;
  fetch_act_e         act;
  logic               unused_redirect_bits;

  assign unused_redirect_bits = ^bus.redirect_pc[1:0];

  always_comb begin
    act           = decode_act(bus.redirect, bus.stall);
    pc_d          = pc_q;
    skip_lo_d     = skip_lo_q;
    fetch_count_d = fetch_count_q;
    case (act)
      // Word-granular target: fetch the aligned pair, drop its low word once.
      ACT_REDIRECT: begin
        pc_d      = bus.redirect_pc[31:3];
        skip_lo_d = bus.redirect_pc[2];
      end
      ACT_ADVANCE: begin
        pc_d          = pc_q + PC_INCR;
        skip_lo_d     = 1'b0;
        fetch_count_d = fetch_count_q + COUNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC_ALIGNED[31:3];
      skip_lo_q     <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      skip_lo_q     <= skip_lo_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_addr   = {pc_q, 3'b000};
  assign bus.fetch_count = fetch_count_q;

  dual_fetch_unit_ifid_pair_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_ifid (
    .clk      (clk),
    .reset    (reset),
    .hold     (act == ACT_STALL),
    .flush    (act == ACT_REDIRECT),
    .slot0_en (~skip_lo_q),
    .pc_in    ({pc_q, 3'b000}),
    .instr_lo (bus.imem_instr1),
    .instr_hi (bus.imem_instr2),
    .id_instr0(bus.id_instr0),
    .id_instr1(bus.id_instr1),
    .id_valid0(bus.id_valid0),
    .id_valid1(bus.id_valid1),
    .id_pc    (bus.id_pc)
  );

endmodule

// File: tb/tb_dual_fetch_unit.sv
// tb/tb_dual_fetch_unit.sv - directed and random checks of dual_fetch_unit against a behavioural model
module tb_dual_fetch_unit;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] MEM_BASE = 32'hA000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  dual_fetch_unit_if #(.COUNT_W(16)) bus ();

  dual_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .COUNT_W (16),
    .NOP_WORD(NOP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Dual-word memory: word k holds MEM_BASE + k.
  assign bus.imem_instr1 = MEM_BASE + (bus.imem_addr >> 2);
  assign bus.imem_instr2 = MEM_BASE + (bus.imem_addr >> 2) + 32'd1;

  logic [31:0] m_pc, m_i0, m_i1, m_idpc;
  logic        m_skip, m_v0, m_v1;
  logic [15:0] m_cnt;

  task automatic model_reset();
    m_pc = 32'h0; m_skip = 1'b0;
    m_i0 = NOP; m_i1 = NOP; m_v0 = 1'b0; m_v1 = 1'b0; m_idpc = 32'h0; m_cnt = 16'h0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".imem_addr"}, bus.imem_addr, m_pc);
    chk({tag, ".valid0"}, {31'b0, bus.id_valid0}, {31'b0, m_v0});
    chk({tag, ".valid1"}, {31'b0, bus.id_valid1}, {31'b0, m_v1});
    chk({tag, ".instr0"}, bus.id_instr0, m_i0);
    chk({tag, ".instr1"}, bus.id_instr1, m_i1);
    if (m_v0 || m_v1) chk({tag, ".id_pc"}, bus.id_pc, m_idpc);
    chk({tag, ".count"}, {16'b0, bus.fetch_count}, {16'b0, m_cnt});
  endtask

  // One clock: drive inputs, advance the model by the fetch rules, check after the edge.
  task automatic step(input string tag, input logic st, input logic rd, input logic [31:0] rpc);
    bus.stall = st; bus.redirect = rd; bus.redirect_pc = rpc;
    if (rd) begin
      m_pc = {rpc[31:3], 3'b000}; m_skip = rpc[2];
      m_v0 = 1'b0; m_v1 = 1'b0; m_i0 = NOP; m_i1 = NOP;
    end else if (!st) begin
      m_v0 = !m_skip;
      m_i0 = m_skip ? NOP : MEM_BASE + m_pc / 4;
      m_v1 = 1'b1;
      m_i1 = MEM_BASE + m_pc / 4 + 32'd1;
      m_idpc = m_pc;
      m_pc = m_pc + 32'd8;
      m_skip = 1'b0;
      m_cnt = m_cnt + 16'd1;
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    reset = 1'b0;

    for (int i = 0; i < 2; i++) step("advance", 1'b0, 1'b0, 32'h0);
    chk("at_0x10", bus.imem_addr, 32'h10);
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 32'h0);
    step("resume", 1'b0, 1'b0, 32'h0);
    chk("resume_pc", bus.id_pc, 32'h10);

    step("redir28", 1'b0, 1'b1, 32'h28);
    step("after28", 1'b0, 1'b0, 32'h0);
    chk("after28_i0", bus.id_instr0, 32'hA000_000A);

    step("redir2c", 1'b0, 1'b1, 32'h2C);
    step("odd_slot", 1'b0, 1'b0, 32'h0);
    chk("odd_slot_i1", bus.id_instr1, 32'hA000_000B);
    step("after2c", 1'b0, 1'b0, 32'h0);

    step("redir_stall", 1'b1, 1'b1, 32'h40);
    step("bubble_hold", 1'b1, 1'b0, 32'h0);
    step("bubble_hold", 1'b1, 1'b0, 32'h0);
    step("after40", 1'b0, 1'b0, 32'h0);
    chk("at_0x48", bus.imem_addr, 32'h48);

    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_model("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("restart", 1'b0, 1'b0, 32'h0);
    chk("restart_pc", bus.id_pc, 32'h0);

    step("redir_top", 1'b0, 1'b1, 32'hFFFF_FFFC);
    step("wrap", 1'b0, 1'b0, 32'h0);
    step("wrapped", 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic st, rd;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      tgt = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'hFF);
      step("random", st, rd, tgt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
